// File: rtl/tt_slot_mux_pkg.sv
// Shared types and bus field offsets for the slot mux.
// Build option: TT_SLOT_MUX_OE_MASK_EN masks uio_out with uio_oe in RUN.
package tt_slot_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    RESET,
    RUN
  } state_t;

  localparam int IW_CLK         = 0;
  localparam int IW_RST_N       = 1;
  localparam int OW_UIO_OUT_LSB = 8;
  localparam int OW_UIO_OE_LSB  = 16;
  localparam int OW_FIELD_W     = 8;

  function automatic int cnt_width(input int g, input int r);
    int m;
    m = (g > r) ? g : r;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tt_slot_mux_seq.sv
// Slot switch sequencer: select handshake, guard/reset timing,
// target and live-slot registers.
module tt_slot_mux_seq
  import tt_slot_mux_pkg::*;
#(
  parameter int N_SLOTS      = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int RST_CYCLES   = 4,
  parameter int SW           = $clog2(N_SLOTS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_valid,
  input  logic [SW-1:0] sel_addr,
  output logic          sel_ready,
  output logic          accept,
  output state_t        state,
  output logic [SW-1:0] active,
  output logic          busy
);

  localparam int CW = cnt_width(GUARD_CYCLES, RST_CYCLES);
  localparam logic [SW-1:0] NONE   = SW'(N_SLOTS);
  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RST_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [SW-1:0] target;

  assign sel_ready = (state == IDLE) || (state == RUN);
  assign busy      = (state == GUARD) || (state == RESET);
  assign accept    = sel_valid && sel_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= NONE;
      active <= NONE;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (accept) begin
            state  <= GUARD;
            target <= sel_addr;
            cnt    <= '0;
            active <= NONE;
          end
        end
        GUARD: begin
          if (cnt == G_LAST) begin
            cnt <= '0;
            if (target >= NONE) begin
              state  <= IDLE;
              active <= NONE;
            end else begin
              state  <= RESET;
              active <= target;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESET: begin
          if (cnt == R_LAST) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tt_slot_mux_ctrl.sv
// Pad-to-slot multiplexer: one live project slot, sequenced switching.
// Build option: TT_SLOT_MUX_OE_MASK_EN zeroes undriven uio_out bits.
module tt_slot_mux_ctrl
  import tt_slot_mux_pkg::*;
#(
  parameter int N_SLOTS      = 4,
  parameter int IW           = 18,
  parameter int OW           = 24,
  parameter int GUARD_CYCLES = 2,
  parameter int RST_CYCLES   = 4,
  parameter int SW           = $clog2(N_SLOTS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [SW-1:0]         sel_addr,
  input  logic [IW-1:0]         pad_in,
  output logic [OW-1:0]         pad_out,
  output logic [N_SLOTS-1:0]    slot_ena,
  output logic [N_SLOTS*IW-1:0] slot_iw,
  input  logic [N_SLOTS*OW-1:0] slot_ow,
  output logic [SW-1:0]         active,
  output logic                  busy
);

  state_t        state;
  logic          accept;
  logic          st_reset;
  logic          st_run;
  logic [IW-1:0] iw_live;
  logic [OW-1:0] ow_sel;
  logic [OW-1:0] ow_next;

  tt_slot_mux_seq #(
    .N_SLOTS      (N_SLOTS),
    .GUARD_CYCLES (GUARD_CYCLES),
    .RST_CYCLES   (RST_CYCLES),
    .SW           (SW)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .sel_addr  (sel_addr),
    .sel_ready (sel_ready),
    .accept    (accept),
    .state     (state),
    .active    (active),
    .busy      (busy)
  );

  assign st_reset = (state == RESET);
  assign st_run   = (state == RUN);

  always_comb begin
    iw_live = '0;
    unique case (1'b1)
      st_reset: begin
        iw_live           = pad_in;
        iw_live[IW_RST_N] = 1'b0;
      end
      st_run:  iw_live = pad_in;
      default: iw_live = '0;
    endcase
  end

  always_comb begin
    slot_ena = '0;
    slot_iw  = '0;
    ow_sel   = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (active == SW'(k)) begin
        slot_ena[k]          = st_reset || st_run;
        slot_iw[k*IW +: IW]  = iw_live;
        ow_sel               = slot_ow[k*OW +: OW];
      end
    end
  end

  always_comb begin
    ow_next = ow_sel;
`ifdef TT_SLOT_MUX_OE_MASK_EN
    ow_next[OW_UIO_OUT_LSB +: OW_FIELD_W] =
      ow_sel[OW_UIO_OUT_LSB +: OW_FIELD_W] &
      ow_sel[OW_UIO_OE_LSB +: OW_FIELD_W];
`endif
  end

  // Cleared on accept so the first GUARD cycle already reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_out <= '0;
    end else if (st_run && !accept) begin
      pad_out <= ow_next;
    end else begin
      pad_out <= '0;
    end
  end

endmodule

// File: tb/tb_tt_slot_mux_ctrl.sv
// Randomised bench for tt_slot_mux_ctrl against a timeline model.
// Honors TT_SLOT_MUX_OE_MASK_EN when compiled with it.
module tb_tt_slot_mux_ctrl;

  localparam int N  = 4;
  localparam int IW = 18;
  localparam int OW = 24;
  localparam int G  = 2;
  localparam int R  = 4;
  localparam int SW = $clog2(N) + 1;
  localparam int BW = N + N*IW + OW + SW + 2;

  localparam int P_IDLE  = 0;
  localparam int P_GUARD = 1;
  localparam int P_RST   = 2;
  localparam int P_RUN   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel_valid = 1'b0;
  logic          sel_ready;
  logic [SW-1:0] sel_addr = '0;
  logic [IW-1:0] pad_in = '0;
  logic [OW-1:0] pad_out;
  logic [N-1:0]  slot_ena;
  logic [N*IW-1:0] slot_iw;
  logic [N*OW-1:0] slot_ow = '0;
  logic [SW-1:0] active;
  logic          busy;

  int checks = 0;
  int passes = 0;

  // Model: time since the last accepted select decides everything.
  bit          m_on;
  int          m_age;
  int          m_tgt;
  logic [OW-1:0] m_pad;

  tt_slot_mux_ctrl #(
    .N_SLOTS(N), .IW(IW), .OW(OW),
    .GUARD_CYCLES(G), .RST_CYCLES(R), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_addr(sel_addr), .pad_in(pad_in),
    .pad_out(pad_out), .slot_ena(slot_ena),
    .slot_iw(slot_iw), .slot_ow(slot_ow),
    .active(active), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int phase();
    if (!m_on) return P_IDLE;
    if (m_age < G) return P_GUARD;
    if (m_tgt >= N) return P_IDLE;
    if (m_age < G + R) return P_RST;
    return P_RUN;
  endfunction

  function automatic logic [OW-1:0] mask(input logic [OW-1:0] v);
    logic [OW-1:0] r;
    r = v;
`ifdef TT_SLOT_MUX_OE_MASK_EN
    r[15:8] = v[15:8] & v[23:16];
`endif
    return r;
  endfunction

  function automatic logic [BW-1:0] model_exp();
    int p;
    logic [N-1:0]    e;
    logic [N*IW-1:0] iw;
    logic [IW-1:0]   pi;
    logic [SW-1:0]   act;
    p   = phase();
    e   = '0;
    iw  = '0;
    pi  = pad_in;
    act = SW'(N);
    if (p == P_RST || p == P_RUN) begin
      e[m_tgt] = 1'b1;
      act = SW'(m_tgt);
      if (p == P_RST) pi[1] = 1'b0;
      iw[m_tgt*IW +: IW] = pi;
    end
    return {e, iw, m_pad, act,
            1'(p == P_GUARD || p == P_RST),
            1'(p == P_IDLE || p == P_RUN)};
  endfunction

  function automatic logic [BW-1:0] observed();
    return {slot_ena, slot_iw, pad_out, active, busy, sel_ready};
  endfunction

  task automatic model_reset();
    m_on  = 1'b0;
    m_age = 0;
    m_tgt = N;
    m_pad = '0;
  endtask

  // Advance the model over one clock edge using the inputs held then.
  task automatic model_step(output bit acc);
    int p;
    logic [OW-1:0] nxt;
    p   = phase();
    acc = sel_valid && (p == P_IDLE || p == P_RUN);
    nxt = '0;
    if (p == P_RUN && !acc) nxt = mask(slot_ow[m_tgt*OW +: OW]);
    if (rst) begin
      model_reset();
      acc = 1'b0;
    end else begin
      m_pad = nxt;
      if (acc) begin
        m_on  = 1'b1;
        m_age = 0;
        m_tgt = int'(sel_addr);
      end else if (m_on && m_age < 1000) begin
        m_age++;
      end
    end
  endtask

  task automatic drive_rand();
    pad_in = IW'($urandom);
    for (int k = 0; k < N; k++)
      slot_ow[k*OW +: OW] = OW'($urandom);
  endtask

  task automatic test_reset();
    bit a;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive_rand();
      #2;
      checks++;
      if (observed() !== model_exp())
        $display("FAIL reset cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      @(posedge clk);
      model_step(a);
    end
  endtask

  task automatic test_select();
    bit a;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_rand();
      sel_valid = (i == 0);
      sel_addr  = SW'(2);
      #2;
      checks++;
      if (observed() !== model_exp())
        $display("FAIL select cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      @(posedge clk);
      model_step(a);
    end
  endtask

  task automatic test_switch();
    bit a;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_rand();
      sel_valid = (i == 0);
      sel_addr  = SW'(0);
      #2;
      checks++;
      if (observed() !== model_exp())
        $display("FAIL switch cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      @(posedge clk);
      model_step(a);
    end
  endtask

  task automatic test_hold();
    bit a;
    bit pend;
    int hs;
    pend = 1'b0;
    hs   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_rand();
      if (i == 0) begin
        sel_valid = 1'b1;
        sel_addr  = SW'(1);
      end else if (i == 1) begin
        sel_valid = 1'b1;
        sel_addr  = SW'(3);
        pend      = 1'b1;
      end else begin
        sel_valid = pend;
      end
      #2;
      hs += int'(sel_valid && sel_ready);
      checks++;
      if (observed() !== model_exp())
        $display("FAIL hold cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      @(posedge clk);
      model_step(a);
      if (a && i >= 1) pend = 1'b0;
    end
    checks++;
    if (hs !== 2)
      $display("FAIL hold_handshakes got=%0d exp=2", hs);
    else passes++;
  endtask

  task automatic test_deselect();
    bit a;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_rand();
      sel_valid = (i == 0);
      sel_addr  = SW'(7);
      #2;
      checks++;
      if (observed() !== model_exp())
        $display("FAIL deselect cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      @(posedge clk);
      model_step(a);
    end
    checks++;
    if (active !== SW'(N) || slot_ena !== '0)
      $display("FAIL deselect_idle active=%0d ena=%b exp=%0d/0", active, slot_ena, N);
    else passes++;
  endtask

  task automatic test_rst_mid();
    bit a;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive_rand();
      rst       = (i == G + 2);
      sel_valid = (i == 0) || (i == G + 4);
      sel_addr  = SW'(1);
      #2;
      checks++;
      if (observed() !== model_exp())
        $display("FAIL rst_mid cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      @(posedge clk);
      model_step(a);
    end
    rst = 1'b0;
  endtask

  task automatic test_oe_mask();
    bit a;
    logic [7:0] want;
`ifdef TT_SLOT_MUX_OE_MASK_EN
    want = 8'h0F;
`else
    want = 8'hFF;
`endif
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_rand();
      if (i >= 10) begin
        slot_ow[3*OW + 8  +: 8] = 8'hFF;
        slot_ow[3*OW + 16 +: 8] = 8'h0F;
      end
      sel_valid = (i == 0);
      sel_addr  = SW'(3);
      #2;
      checks++;
      if (observed() !== model_exp())
        $display("FAIL oe_mask cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      if (i >= 11) begin
        checks++;
        if (pad_out[15:8] !== want)
          $display("FAIL oe_mask_byte got=%h exp=%h", pad_out[15:8], want);
        else passes++;
      end
      @(posedge clk);
      model_step(a);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive_rand();
      rst       = ($urandom_range(0, 39) == 0);
      sel_valid = ($urandom_range(0, 3) == 0);
      sel_addr  = SW'($urandom_range(0, 7));
      #2;
      checks++;
      if (observed() !== model_exp())
        $display("FAIL b2b cyc%0d got=%h exp=%h", i, observed(), model_exp());
      else passes++;
      @(posedge clk);
      model_step(a);
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_select();
    test_switch();
    test_hold();
    test_deselect();
    test_rst_mid();
    test_oe_mask();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
